// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for EX, owning the HI/LO pair.
// Shift-add multiply and restoring divide share one 2W working register.
module ex_muldiv #(
    parameter int W  = 32,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         i_EX_ctrl_MDValid,
    input  logic [2:0]   i_EX_ctrl_MDOp,
    input  logic [W-1:0] i_EX_data_A,
    input  logic [W-1:0] i_EX_data_B,
    input  logic         i_EX_ctrl_HiLoRead,
    input  logic         i_EX_ctrl_Flush,
    output logic         o_EX_ctrl_Stall,
    output logic         o_EX_ctrl_Busy,
    output logic         o_EX_ctrl_Done,
    output logic [W-1:0] o_EX_data_HI,
    output logic [W-1:0] o_EX_data_LO
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opnd;
    logic [CW-1:0]  cnt;
    logic           is_div;
    logic           neg_lo;
    logic           neg_hi;
    logic           b_zero;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           busy;
    logic           done;

    logic           accept;
    logic           op_sgn;
    logic           sa;
    logic           sb;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     add;
    logic [2*W-1:0] mul_next;
    logic [W:0]     rsh;
    logic [W:0]     diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] fix_p;
    logic [W-1:0]   fix_q;
    logic [W-1:0]   fix_r;

    assign accept = i_EX_ctrl_MDValid & ~busy & ~i_EX_ctrl_Flush;
    assign op_sgn = ~i_EX_ctrl_MDOp[0];

    always_comb begin
        sa    = op_sgn & i_EX_data_A[W-1];
        sb    = op_sgn & i_EX_data_B[W-1];
        mag_a = sa ? (~i_EX_data_A + 1'b1) : i_EX_data_A;
        mag_b = sb ? (~i_EX_data_B + 1'b1) : i_EX_data_B;

        add      = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
        mul_next = acc[0] ? {add, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};

        // restoring step: keep the shifted remainder when the trial goes negative
        rsh      = {acc[2*W-1:W], acc[W-1]};
        diff     = rsh - {1'b0, opnd};
        div_next = diff[W] ? {rsh[W-1:0], acc[W-2:0], 1'b0}
                           : {diff[W-1:0], acc[W-2:0], 1'b1};

        fix_p = neg_lo ? (~acc + 1'b1) : acc;
        fix_q = b_zero ? '1
              : (neg_lo ? (~acc[W-1:0] + 1'b1) : acc[W-1:0]);
        fix_r = neg_hi ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (i_EX_ctrl_MDOp)
                            3'b100: hi <= i_EX_data_A;
                            3'b101: lo <= i_EX_data_A;
                            3'b110, 3'b111: ;
                            default: begin
                                is_div <= i_EX_ctrl_MDOp[1];
                                b_zero <= (i_EX_data_B == '0);
                                opnd   <= i_EX_ctrl_MDOp[1] ? mag_b : mag_a;
                                acc    <= {{W{1'b0}},
                                           i_EX_ctrl_MDOp[1] ? mag_a : mag_b};
                                // a zero divisor forces LO to all ones instead
                                neg_lo <= (sa ^ sb) &
                                          ~(i_EX_ctrl_MDOp[1] & (i_EX_data_B == '0));
                                neg_hi <= sa;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= CALC;
                            end
                        endcase
                    end
                end
                CALC: begin
                    if (i_EX_ctrl_Flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(W - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!i_EX_ctrl_Flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            lo <= fix_q;
                            hi <= fix_r;
                        end else begin
                            lo <= fix_p[W-1:0];
                            hi <= fix_p[2*W-1:W];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_EX_ctrl_Stall = busy & (i_EX_ctrl_MDValid | i_EX_ctrl_HiLoRead);
    assign o_EX_ctrl_Busy  = busy;
    assign o_EX_ctrl_Done  = done;
    assign o_EX_data_HI    = hi;
    assign o_EX_data_LO    = lo;

endmodule
